// File: rtl/wide_add_seq_if.sv
// Requester-side bus for wide_add_seq: Start/Ready/Done handshake, operands and result.
// The Sub signal exists only when WIDE_ADD_SUB_EN is defined.
interface wide_add_seq_if #(
    parameter int N     = 4,
    parameter int WORDS = 4
);
    localparam int W = N * WORDS;

    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
`ifdef WIDE_ADD_SUB_EN
    logic         Sub;
`endif
    logic         Ready;
    logic         Busy;
    logic         Done;
    logic [W-1:0] S;
    logic         Cout;

    modport slave (
`ifdef WIDE_ADD_SUB_EN
        input  Start, A, B, Cin, Sub,
`else
        input  Start, A, B, Cin,
`endif
        output Ready, Busy, Done, S, Cout
    );

    modport master (
`ifdef WIDE_ADD_SUB_EN
        output Start, A, B, Cin, Sub,
`else
        output Start, A, B, Cin,
`endif
        input  Ready, Busy, Done, S, Cout
    );
endinterface

// File: rtl/wide_add_seq.sv
// Multi-word adder: one shared N-bit ripple-carry adder processes N*WORDS-bit operands
// one word per clock, LS word first. Optional subtract mode under macro WIDE_ADD_SUB_EN.
module RCA #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_s,
    output logic         o_cout
);
    logic [N:0] w_c;

    assign w_c[0] = i_cin;
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_fa
            assign o_s[gi]     = i_a[gi] ^ i_b[gi] ^ w_c[gi];
            assign w_c[gi + 1] = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
        end
    endgenerate
    assign o_cout = w_c[N];
endmodule

module wide_add_seq #(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic          clk,
    input  logic          rst,
    wide_add_seq_if.slave bus
);
    localparam int W  = N * WORDS;
    localparam int KW = $clog2(WORDS);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic           w_accept;
    logic           w_last;

    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [KW-1:0]  r_k;
    logic           r_c;
    logic           r_cout;
    logic [N-1:0]   r_s_words [WORDS];
`ifdef WIDE_ADD_SUB_EN
    logic           r_sub;
`endif

    logic [N-1:0]   w_a_words [WORDS];
    logic [N-1:0]   w_b_words [WORDS];
    logic [N-1:0]   w_a_word;
    logic [N-1:0]   w_b_word;
    logic [N-1:0]   w_b_op;
    logic [N-1:0]   w_sum;
    logic           w_carry;

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
            assign w_a_words[gi]      = r_a[gi*N +: N];
            assign w_b_words[gi]      = r_b[gi*N +: N];
            assign bus.S[gi*N +: N]   = r_s_words[gi];
        end
    endgenerate

    assign w_a_word = w_a_words[r_k];
    assign w_b_word = w_b_words[r_k];
    assign w_last   = (r_k == KW'(WORDS - 1));

    // Subtraction is A + ~B + 1: invert B here, force the initial carry to 1 on accept.
`ifdef WIDE_ADD_SUB_EN
    assign w_b_op = r_sub ? ~w_b_word : w_b_word;
`else
    assign w_b_op = w_b_word;
`endif

    RCA #(.N(N)) u_rca (
        .i_a    (w_a_word),
        .i_b    (w_b_op),
        .i_cin  (r_c),
        .o_s    (w_sum),
        .o_cout (w_carry)
    );

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        bus.Ready    = 1'b0;
        bus.Busy     = 1'b0;
        bus.Done     = 1'b0;
        case (r_state)
            IDLE: begin
                bus.Ready = 1'b1;
                if (bus.Start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                bus.Busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                bus.Done     = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign bus.Cout = r_cout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_k     <= '0;
            r_c     <= 1'b0;
            r_cout  <= 1'b0;
`ifdef WIDE_ADD_SUB_EN
            r_sub   <= 1'b0;
`endif
            for (int i = 0; i < WORDS; i++) begin
                r_s_words[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a <= bus.A;
                r_b <= bus.B;
                r_k <= '0;
`ifdef WIDE_ADD_SUB_EN
                r_sub <= bus.Sub;
                r_c   <= bus.Sub ? 1'b1 : bus.Cin;
`else
                r_c   <= bus.Cin;
`endif
            end
            if (r_state == RUN) begin
                r_s_words[r_k] <= w_sum;
                r_c            <= w_carry;
                r_k            <= r_k + 1'b1;
                if (w_last) begin
                    r_cout <= w_carry;
                end
            end
        end
    end
endmodule
